// File: rtl/dma_copy_pkg.sv
// rtl/dma_copy_pkg.sv - shared types and constants for the DMA copy engine
package dma_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] CSR_STATUS  = 3'd0;
    localparam logic [2:0] CSR_SRC     = 3'd1;
    localparam logic [2:0] CSR_DST     = 3'd2;
    localparam logic [2:0] CSR_LEN     = 3'd3;
    localparam logic [2:0] CSR_CONTROL = 3'd4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERROR   = 2;
    localparam int STAT_ABORTED = 3;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 3;

    localparam int LEN_W = 18;

endpackage

// File: rtl/dma_copy_buf.sv
// rtl/dma_copy_buf.sv - chunk buffer register file with write/read index counters
module dma_copy_buf #(
    parameter int BUF_DEPTH = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_clr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Write index restarts at every chunk so word i of the chunk lands in slot i
    always_ff @(posedge clk) begin
        if (reset || wr_clr) begin
            wr_idx <= '0;
        end else if (wr_en) begin
            wr_idx <= wr_idx + 1'b1;
        end
    end

    // Read index walks the chunk during the write-out phase
    always_ff @(posedge clk) begin
        if (reset || rd_clr) begin
            rd_idx <= '0;
        end else if (rd_en) begin
            rd_idx <= rd_idx + 1'b1;
        end
    end

    // Data array carries no reset; every slot is written before it is read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = buf_mem[rd_idx];

endmodule

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - chunked memory-to-memory copy master with CSR slave
module dma_copy_engine
    import dma_copy_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 102400,
    parameter int BUF_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int CHK_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    state_t             state;
    state_t             next_state;

    logic [ADDR_W-1:0]  src_reg;
    logic [ADDR_W-1:0]  dst_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               irq_en;
    logic               done;
    logic               error;
    logic               aborted;

    logic [PTR_W-1:0]   src_ptr;
    logic [PTR_W-1:0]   dst_ptr;
    logic [LEN_W-1:0]   remaining;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   chunk;
    logic               cnt_last;

    logic               busy;
    logic               ctrl_wr;
    logic               go_req;
    logic               abort_req;
    logic               w1c;
    logic               range_err;

    logic [CHK_W-1:0]   src_ext;
    logic [CHK_W-1:0]   dst_ext;
    logic [CHK_W-1:0]   src_end;
    logic [CHK_W-1:0]   dst_end;

    logic               buf_wr_en;
    logic [DATA_W-1:0]  buf_rd_data;

    logic               unused_bits;

    assign busy      = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_WRITE);
    assign ctrl_wr   = csr_write && (csr_address == CSR_CONTROL);
    assign go_req    = ctrl_wr && csr_writedata[CTRL_GO] && (state == ST_IDLE);
    assign abort_req = ctrl_wr && csr_writedata[CTRL_ABORT] && busy;
    assign w1c       = csr_write && (csr_address == CSR_STATUS);

    // Bounds are checked in a width that cannot overflow for any SRC/DST/LEN
    assign src_ext   = CHK_W'(src_reg);
    assign dst_ext   = CHK_W'(dst_reg);
    assign src_end   = src_ext + CHK_W'(len_reg);
    assign dst_end   = dst_ext + CHK_W'(len_reg);
    assign range_err = (src_end > CHK_W'(MEM_DEPTH)) || (dst_end > CHK_W'(MEM_DEPTH)) ||
                       ((dst_ext > src_ext) && (dst_ext < src_end));

    assign chunk    = (remaining >= LEN_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : CNT_W'(remaining);
    assign cnt_last = (cnt == chunk - 1'b1);

    assign irq = done & irq_en;

    assign unused_bits = ^{csr_writedata[31:LEN_W], src_ptr[ADDR_W], dst_ptr[ADDR_W]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and memory-port outputs
    always_comb begin
        next_state     = state;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = 4'hF;
        case (state)
            ST_IDLE: begin
                if (go_req) begin
                    if (range_err || (len_reg == '0)) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_chipselect = 1'b1;
                mem_address    = src_ptr[ADDR_W-1:0];
                if (abort_req) begin
                    next_state = ST_DONE;
                end else if (cnt_last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                next_state = abort_req ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_ptr[ADDR_W-1:0];
                mem_writedata  = buf_rd_data;
                if (abort_req) begin
                    next_state = ST_DONE;
                end else if (cnt_last) begin
                    next_state = (remaining == LEN_W'(chunk)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Programming registers; address/length are frozen while a copy runs
    always_ff @(posedge clk) begin
        if (reset) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            irq_en  <= 1'b0;
        end else if (csr_write) begin
            case (csr_address)
                CSR_SRC:     if (!busy) src_reg <= csr_writedata[ADDR_W-1:0];
                CSR_DST:     if (!busy) dst_reg <= csr_writedata[ADDR_W-1:0];
                CSR_LEN:     if (!busy) len_reg <= csr_writedata[LEN_W-1:0];
                CSR_CONTROL: irq_en <= csr_writedata[CTRL_IRQ_EN];
                default:     ;
            endcase
        end
    end

    // Status flags: clears first, then sets, so a set in the same cycle wins
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            error   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (go_req) begin
                done    <= 1'b0;
                error   <= 1'b0;
                aborted <= 1'b0;
            end else if (w1c) begin
                if (csr_writedata[STAT_DONE])    done    <= 1'b0;
                if (csr_writedata[STAT_ERROR])   error   <= 1'b0;
                if (csr_writedata[STAT_ABORTED]) aborted <= 1'b0;
            end
            if ((next_state == ST_DONE) || (state == ST_DONE)) done <= 1'b1;
            if (go_req && range_err) error <= 1'b1;
            if (abort_req) aborted <= 1'b1;
        end
    end

    // Pointers, remaining count and per-chunk beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (go_req) begin
                        src_ptr   <= PTR_W'(src_reg);
                        dst_ptr   <= PTR_W'(dst_reg);
                        remaining <= len_reg;
                    end
                end
                ST_READ: begin
                    src_ptr <= src_ptr + 1'b1;
                    cnt     <= cnt_last ? '0 : cnt + 1'b1;
                end
                ST_WRITE: begin
                    dst_ptr <= dst_ptr + 1'b1;
                    if (cnt_last) begin
                        cnt       <= '0;
                        remaining <= remaining - LEN_W'(chunk);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Read data for beat i arrives while beat i+1 (or the drain cycle) is on the bus
    assign buf_wr_en = ((state == ST_READ) && (cnt != '0)) || (state == ST_DRAIN);

    dma_copy_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .DATA_W    (DATA_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr_en),
        .wr_clr  (!((state == ST_READ) || (state == ST_DRAIN))),
        .wr_data (mem_readdata),
        .rd_en   (state == ST_WRITE),
        .rd_clr  (state != ST_WRITE),
        .rd_data (buf_rd_data)
    );

    // Registered CSR read mux; STATUS reflects the values before this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                CSR_STATUS:  csr_readdata <= {28'd0, aborted, error, done, busy};
                CSR_SRC:     csr_readdata <= 32'(src_reg);
                CSR_DST:     csr_readdata <= 32'(dst_reg);
                CSR_LEN:     csr_readdata <= 32'(len_reg);
                CSR_CONTROL: csr_readdata <= {30'd0, irq_en, 1'b0};
                default:     csr_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - directed self-checking bench for dma_copy_engine
module tb_dma_copy_engine;
    import dma_copy_pkg::*;

    typedef struct {
        int          edge_n;
        bit          we;
        logic [16:0] addr;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  csr_address;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [16:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    bit [31:0]   ram [0:4095];
    bit          written [0:4095];
    acc_t        acc_q [$];
    int          cyc = 0;
    int          go_edge;
    int          base;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_read       (csr_read),
        .csr_readdata   (csr_readdata),
        .irq            (irq),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    function automatic logic [31:0] pattern(input logic [16:0] a);
        if (a >= 17'h100 && a < 17'h104) return 32'hA0 + 32'(a - 17'h100);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic acc_t mk_acc(input int e, input bit we, input logic [16:0] a, input logic [31:0] d);
        acc_t r;
        r.edge_n = e; r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    // RAM model: one-cycle read latency, sources fall back to a fixed pattern
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect) begin
            acc_q.push_back(mk_acc(cyc, mem_write, mem_address, mem_writedata));
            if (mem_write) begin
                ram[mem_address[11:0]]     <= mem_writedata;
                written[mem_address[11:0]] <= 1'b1;
            end else begin
                mem_readdata <= written[mem_address[11:0]] ? ram[mem_address[11:0]] : pattern(mem_address);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        csr_wr(CSR_SRC, s);
        csr_wr(CSR_DST, d);
        csr_wr(CSR_LEN, l);
    endtask

    task automatic go(input logic [31:0] ctrl);
        base = acc_q.size();
        csr_wr(CSR_CONTROL, ctrl);
        go_edge = cyc - 1;
    endtask

    task automatic check_acc(input string tag, input int idx, input int rel, input bit we, input logic [16:0] addr);
        check({tag, "_present"}, 32'(idx < acc_q.size()), 32'd1);
        if (idx < acc_q.size()) begin
            check({tag, "_edge"}, 32'(acc_q[idx].edge_n - go_edge), 32'(rel));
            check({tag, "_we"}, 32'(acc_q[idx].we), 32'(we));
            check({tag, "_addr"}, 32'(acc_q[idx].addr), 32'(addr));
        end
    endtask

    task automatic check_copy(input string tag, input logic [16:0] s, input logic [16:0] d, input int len);
        for (int i = 0; i < len; i++) begin
            logic [16:0] da;
            da = d + 17'(i);
            check(tag, ram[da[11:0]], pattern(s + 17'(i)));
        end
    endtask

    function automatic int count_acc(input int from, input bit writes_only);
        int n = 0;
        for (int i = from; i < acc_q.size(); i++) begin
            if (!writes_only || acc_q[i].we) n++;
        end
        return n;
    endfunction

    initial begin
        reset = 1'b1; csr_address = '0; csr_write = 1'b0; csr_writedata = '0; csr_read = 1'b0;
        idle(2);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_we", 32'(mem_write), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_be", 32'(mem_byteenable), 32'hF);
        check("rst_rdata", csr_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        csr_rd(CSR_STATUS, rd);  check("rst_status", rd, 32'd0);
        csr_rd(CSR_SRC, rd);     check("rst_src", rd, 32'd0);

        // LEN=4 basic copy with interrupt
        setup(32'h100, 32'h200, 32'd4);
        go(32'h3);
        idle(8);
        csr_rd(CSR_STATUS, rd);  check("t1_busy_last", rd, 32'h1);
        csr_rd(CSR_STATUS, rd);  check("t1_done", rd, 32'h2);
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_nacc", 32'(acc_q.size() - base), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check_acc("t1_rd", base + i, i + 1, 1'b0, 17'h100 + 17'(i));
            check_acc("t1_wr", base + 4 + i, i + 6, 1'b1, 17'h200 + 17'(i));
        end
        check_copy("t1_copy", 17'h100, 17'h200, 4);
        csr_wr(CSR_STATUS, 32'h2);
        check("t1_irq_clr", 32'(irq), 32'd0);

        // LEN=20 in chunks of 8, 8, 4
        setup(32'h300, 32'h400, 32'd20);
        go(32'h1);
        idle(42);
        csr_rd(CSR_STATUS, rd);  check("t2_busy_last", rd, 32'h1);
        csr_rd(CSR_STATUS, rd);  check("t2_done", rd, 32'h2);
        check("t2_nacc", 32'(acc_q.size() - base), 32'd40);
        check("t2_nwr", 32'(count_acc(base, 1'b1)), 32'd20);
        check_acc("t2_c1w0", base + 8, 10, 1'b1, 17'h400);
        check_acc("t2_c2r0", base + 16, 18, 1'b0, 17'h308);
        check_acc("t2_c3w3", base + 39, 43, 1'b1, 17'h413);
        check_copy("t2_copy", 17'h300, 17'h400, 20);

        // LEN=0 and out-of-range source
        setup(32'h20, 32'h40, 32'd0);
        go(32'h1);
        csr_rd(CSR_STATUS, rd);  check("t3_len0", rd, 32'h2);
        idle(3);
        check("t3_len0_nacc", 32'(count_acc(base, 1'b0)), 32'd0);
        setup(32'd102398, 32'd0, 32'd4);
        go(32'h1);
        csr_rd(CSR_STATUS, rd);  check("t3_range", rd, 32'h6);
        idle(3);
        check("t3_range_nacc", 32'(count_acc(base, 1'b0)), 32'd0);

        // Overlapping destination rejected, destination below source accepted
        setup(32'h10, 32'h12, 32'd8);
        go(32'h1);
        csr_rd(CSR_STATUS, rd);  check("t4_overlap", rd, 32'h6);
        idle(3);
        check("t4_overlap_nacc", 32'(count_acc(base, 1'b0)), 32'd0);
        csr_wr(CSR_DST, 32'h08);
        go(32'h1);
        idle(16);
        csr_rd(CSR_STATUS, rd);  check("t4_below_busy", rd, 32'h1);
        csr_rd(CSR_STATUS, rd);  check("t4_below_done", rd, 32'h2);
        check_copy("t4_copy", 17'h10, 17'h08, 8);

        // ABORT on the third write beat, then restart
        setup(32'h500, 32'h600, 32'd8);
        go(32'h1);
        idle(11);
        csr_wr(CSR_CONTROL, 32'h8);
        csr_rd(CSR_STATUS, rd);  check("t5_aborted", rd, 32'hA);
        idle(4);
        check("t5_nwr", 32'(count_acc(base, 1'b1)), 32'd3);
        check("t5_nacc", 32'(count_acc(base, 1'b0)), 32'd11);
        check_copy("t5_partial", 17'h500, 17'h600, 3);
        check("t5_untouched", 32'(written[12'h603]), 32'd0);
        csr_wr(CSR_DST, 32'h680);
        go(32'h3);
        idle(16);
        csr_rd(CSR_STATUS, rd);  check("t5_re_busy", rd, 32'h1);
        csr_rd(CSR_STATUS, rd);  check("t5_re_done", rd, 32'h2);
        check("t5_re_irq", 32'(irq), 32'd1);
        check_copy("t5_re_copy", 17'h500, 17'h680, 8);

        // Busy gating and W1C landing in the DONE cycle
        setup(32'h100, 32'h240, 32'd4);
        go(32'h1);
        csr_wr(CSR_SRC, 32'h555);
        csr_wr(CSR_CONTROL, 32'h3);
        idle(7);
        csr_wr(CSR_STATUS, 32'h2);
        csr_rd(CSR_STATUS, rd);  check("t6_done_kept", rd, 32'h2);
        check("t6_irq", 32'(irq), 32'd1);
        csr_rd(CSR_SRC, rd);     check("t6_src_kept", rd, 32'h100);
        idle(3);
        check("t6_nacc", 32'(count_acc(base, 1'b0)), 32'd8);
        check_copy("t6_copy", 17'h100, 17'h240, 4);
        csr_wr(CSR_STATUS, 32'h2);
        csr_rd(CSR_STATUS, rd);  check("t6_w1c", rd, 32'h0);

        // Reset during READ
        setup(32'h300, 32'h480, 32'd8);
        go(32'h3);
        csr_rd(CSR_SRC, rd);     check("t7_src", rd, 32'h300);
        idle(1);
        check("t7_cs_pre", 32'(mem_chipselect), 32'd1);
        reset = 1'b1;
        idle(1);
        check("t7_cs", 32'(mem_chipselect), 32'd0);
        check("t7_we", 32'(mem_write), 32'd0);
        check("t7_addr", 32'(mem_address), 32'd0);
        check("t7_wdata", mem_writedata, 32'd0);
        check("t7_be", 32'(mem_byteenable), 32'hF);
        check("t7_irq", 32'(irq), 32'd0);
        check("t7_rdata", csr_readdata, 32'd0);
        reset = 1'b0;
        base = acc_q.size();
        csr_rd(CSR_STATUS, rd);  check("t7_status", rd, 32'h0);
        csr_rd(CSR_SRC, rd);     check("t7_src_rst", rd, 32'h0);
        csr_rd(CSR_CONTROL, rd); check("t7_ctrl_rst", rd, 32'h0);
        check("t7_nacc", 32'(count_acc(base, 1'b0)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory copy master sitting directly upstream of the 102400 x 32 on-chip RAM; it drives the RAM's dedicated second slave port.
- Nios II programs source, destination and length through a small CSR slave, then sets GO.
- The block moves words in chunks of up to BUF_DEPTH: read burst into a local buffer, then write burst out, with done/error status and an interrupt.

Parameters:
- ADDR_W, 17, word-address width of the RAM port.
- DATA_W, 32, data width; fixed byteenable of all ones.
- MEM_DEPTH, 102400, number of valid words; used for range checking.
- BUF_DEPTH, 8, chunk buffer depth in words; power of two, 1..64.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- csr_address  in  3  word offset: 0 STATUS, 1 SRC, 2 DST, 3 LEN, 4 CONTROL
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  registered, valid cycle after csr_read
- irq  out  1  level interrupt = done & irq_en
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  access strobe
- mem_write  out  1  write strobe, only with chipselect
- mem_byteenable  out  4  constant 4'hF
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM read data, valid exactly 1 cycle after address (no waitrequest)

Behaviour:
- Reset: state IDLE; SRC/DST/LEN/irq_en = 0; busy/done/error/aborted = 0; all mem_* outputs 0 except byteenable; csr_readdata = 0; irq = 0.
- CSR register map:
  - STATUS: bit0 busy, bit1 done (W1C), bit2 error, bit3 aborted; bits 2 and 3 also clear on W1C.
  - CONTROL: bit0 GO (self-clearing), bit1 irq_en, bit3 ABORT (self-clearing).
  - SRC/DST: low ADDR_W bits used. LEN: low 18 bits, in words.
- Busy gating: writes to SRC/DST/LEN while busy are ignored. GO while busy is ignored. irq_en is writable at any time.
- GO accepted in IDLE:
  - Clears done/error/aborted on the same edge.
  - Range check: if SRC+LEN > MEM_DEPTH, or DST+LEN > MEM_DEPTH, or DST is inside (SRC, SRC+LEN), go to DONE with error=1 and issue no memory access.
  - If LEN=0, go to DONE with error=0 and no access.
  - Otherwise go to READ with busy=1.
- States and transitions:
  - IDLE: waits for an accepted GO, as above.
  - READ: one read per cycle with chipselect=1, write=0, address=src_ptr; src_ptr++. Runs for C = min(BUF_DEPTH, remaining) cycles, then DRAIN.
  - DRAIN: 1 cycle with chipselect=0, capturing the last read word, then WRITE.
  - Data capture: mem_readdata is captured into buffer[i] one cycle after read i is issued.
  - WRITE: one write per cycle with chipselect=1, write=1, address=dst_ptr, writedata=buffer[i]; dst_ptr++. Runs for C cycles. Then remaining -= C; go to READ if remaining > 0, else DONE.
  - DONE: 1 cycle; busy=0, done=1, then IDLE.
- Timing: a chunk of C words costs 2C+1 cycles. For LEN=4, BUF_DEPTH=8, busy is high for 9 cycles plus the DONE cycle.
- ABORT while busy:
  - Takes effect at the next edge; no further memory accesses are issued.
  - A write driven in the abort cycle completes; the buffer is discarded.
  - Goes to DONE with aborted=1. ABORT in IDLE has no effect.
- Simultaneous events:
  - W1C of done in the same cycle DONE sets it: set wins.
  - GO and ABORT in the same write: ABORT is ignored if idle; GO starts the transfer.
  - CSR read of STATUS returns the pre-edge values.
- Pointer rules: pointers never wrap, because the range check guarantees that. The arithmetic is done in ADDR_W+1 bits.
- Reset mid-transfer: immediate return to the reset state. The partially written destination is left as is.

Decomposition:
- Shared package dma_copy_pkg holds:
  - the state enum (IDLE, READ, DRAIN, WRITE, DONE)
  - CSR offset constants
  - STATUS/CONTROL bit index constants
- Sub-module dma_copy_buf: BUF_DEPTH x DATA_W register file with one write port and one read port, plus index counters; no reset on the data array.

Test Plan:
- SRC=0x100, DST=0x200, LEN=4, pre-loaded 0xA0..0xA3 -> reads at 0x100..0x103 on consecutive cycles, one DRAIN cycle, writes 0xA0..0xA3 to 0x200..0x203, done=1 after 9 busy cycles, irq=1 with irq_en.
- LEN=20, BUF_DEPTH=8 -> three chunks (8, 8, 4), busy for 17+17+9 cycles, destination matches the source word for word.
- LEN=0 -> done=1, error=0, mem_chipselect never asserted. SRC=102398, LEN=4 -> error=1, no access.
- SRC=0x10, DST=0x12, LEN=8 (overlap) -> error=1, no access. DST=0x08 (below SRC) -> copy succeeds.
- ABORT on the third write of LEN=8 -> at most 3 destination words written, aborted=1, done=1, then GO restarts cleanly.
- Write SRC while busy, GO while busy, and W1C of done coinciding with DONE -> register unchanged, GO ignored, done stays 1; reset asserted mid-READ -> all outputs return to reset values the next cycle.
